// File: rtl/darktimer_if.sv
// ============================================================================
// darktimer_if : word-access bus between a host and the darktimer block
// Rev 1.0
// ============================================================================
`default_nettype none

interface darktimer_if;
  logic        XDREQ;
  logic        XWR;
  logic        XRD;
  logic [3:0]  XBE;
  logic [31:0] XADDR;
  logic [31:0] XATAI;
  logic [31:0] XATAO;
  logic        XDACK;
  logic        XIRQ;
  logic [3:0]  DEBUG;

  modport master (
    output XDREQ, XWR, XRD, XBE, XADDR, XATAI,
    input  XATAO, XDACK, XIRQ, DEBUG
  );

  modport slave (
    input  XDREQ, XWR, XRD, XBE, XADDR, XATAI,
    output XATAO, XDACK, XIRQ, DEBUG
  );
endinterface

`default_nettype wire

// File: rtl/darktimer.sv
// ============================================================================
// darktimer : NCH-channel down-counting timer with pending/mask interrupt;
//             DARKTIMER_PRESCALER_EN adds a 16-bit tick prescaler. Rev 1.0
// ============================================================================
`default_nettype none

module darktimer #(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input wire         CLK,
  input wire         RESN,
  darktimer_if.slave bus
);

  localparam logic [CW-1:0] C_ONE = 1;

  logic              w_wr;
  logic              w_rd;
  logic [5:0]        w_idx;
  logic              w_ch_hit;
  logic [3:0]        w_ch_sel;
  logic [1:0]        w_ch_off;
  logic              w_tick;
  logic [15:0]       w_prescale_rd;
  logic [NCH-1:0]    w_expire;
  logic [NCH-1:0]    w_w1c;
  logic [31:0]       w_rd_mux;
  logic              w_unused;

  logic [NCH-1:0]    r_pend;
  logic [NCH-1:0]    r_mask;
  logic [CW-1:0]     r_reload [NCH];
  logic [CW-1:0]     r_count  [NCH];
  logic [NCH-1:0]    r_en;
  logic [NCH-1:0]    r_per;
  logic              r_ack;
  logic [31:0]       r_rdata;

  // A write owns its cycle; a read is refused while its predecessor is still being acknowledged
  assign w_wr     = bus.XDREQ && bus.XWR;
  assign w_rd     = bus.XDREQ && bus.XRD && !bus.XWR && !r_ack;
  assign w_idx    = bus.XADDR[7:2];
  assign w_ch_hit = (w_idx[5:2] != 4'd0);
  assign w_ch_sel = w_idx[5:2] - 4'd1;
  assign w_ch_off = w_idx[1:0];
  assign w_w1c    = (w_wr && w_idx == 6'd1) ? bus.XATAI[NCH-1:0] : '0;
  assign w_unused = ^{bus.XBE, bus.XADDR, bus.XATAI};

`ifdef DARKTIMER_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      r_prescale <= '0;
      r_pcnt     <= '0;
    end else if (w_wr && w_idx == 6'd3) begin
      r_prescale <= bus.XATAI[15:0];
      r_pcnt     <= bus.XATAI[15:0];
    end else if (r_pcnt == 16'd0) begin
      r_pcnt <= r_prescale;
    end else begin
      r_pcnt <= r_pcnt - 16'd1;
    end
  end

  assign w_tick        = (r_pcnt == 16'd0);
  assign w_prescale_rd = r_prescale;
`else
  assign w_tick        = 1'b1;
  assign w_prescale_rd = '0;
`endif

  always_comb begin
    w_expire = '0;
    for (int n = 0; n < NCH; n++) begin
      w_expire[n] = w_tick && r_en[n] && (r_count[n] == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      for (int n = 0; n < NCH; n++) begin
        r_reload[n] <= '0;
        r_count[n]  <= '0;
      end
      r_en  <= '0;
      r_per <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (w_tick && r_en[n]) begin
          if (r_count[n] != '0) begin
            r_count[n] <= r_count[n] - C_ONE;
          end else if (r_per[n]) begin
            r_count[n] <= r_reload[n];
          end else begin
            r_en[n] <= 1'b0;
          end
        end
        // Bus writes come last so a CTRL load or freeze overrides this edge's tick
        if (w_wr && w_ch_hit && w_ch_sel == 4'(n)) begin
          case (w_ch_off)
            2'd0: r_reload[n] <= bus.XATAI[CW-1:0];
            2'd2: begin
              r_en[n]  <= bus.XATAI[0];
              r_per[n] <= bus.XATAI[1];
              if ((bus.XATAI[0] && !r_en[n]) || bus.XATAI[2]) begin
                r_count[n] <= r_reload[n];
              end else if (!bus.XATAI[0]) begin
                r_count[n] <= r_count[n];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      r_pend <= '0;
      r_mask <= '0;
    end else begin
      r_pend <= (r_pend & ~w_w1c) | w_expire;
      if (w_wr && w_idx == 6'd2) begin
        r_mask <= bus.XATAI[NCH-1:0];
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_idx)
      6'd0: w_rd_mux = {16'h0000, 8'(NCH), 8'h01};
      6'd1: w_rd_mux[NCH-1:0] = r_pend;
      6'd2: w_rd_mux[NCH-1:0] = r_mask;
      6'd3: w_rd_mux[15:0] = w_prescale_rd;
      default: begin
        for (int n = 0; n < NCH; n++) begin
          if (w_ch_hit && w_ch_sel == 4'(n)) begin
            case (w_ch_off)
              2'd0:    w_rd_mux[CW-1:0] = r_reload[n];
              2'd1:    w_rd_mux[CW-1:0] = r_count[n];
              2'd2:    w_rd_mux[1:0]    = {r_per[n], r_en[n]};
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESN) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign bus.XATAO = r_rdata;
  assign bus.XDACK = RESN && (w_wr || r_ack);
  assign bus.XIRQ  = RESN && (|(r_pend & r_mask));
  assign bus.DEBUG = {bus.XDREQ, bus.XRD, bus.XWR, bus.XDACK};

endmodule

`default_nettype wire
